// File: rtl/inimigo_movimento.sv
// Enemy sprite motion: marches sideways once per step period, drops a row at each edge.
// Optional INIMIGO_ACCEL_EN shortens the step period by one frame per descent.
module inimigo_movimento #(
    parameter int X_START         = 100,
    parameter int Y_START         = 40,
    parameter int X_MIN           = 8,
    parameter int X_MAX           = 608,
    parameter int STEP_X          = 4,
    parameter int STEP_Y          = 12,
    parameter int Y_LIMIT         = 420,
    parameter int FRAMES_PER_STEP = 30,
    parameter int FRAMES_MIN      = 5,
    parameter int V_ACTIVE        = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    input  logic       hit,
    output logic [9:0] posX,
    output logic [9:0] posY,
    output logic       alive,
    output logic       landed,
    output logic       dir
);

    localparam logic [1:0] MOVE   = 2'd0;
    localparam logic [1:0] DEAD   = 2'd1;
    localparam logic [1:0] LANDED = 2'd2;

    logic [1:0]  state;
    logic        vb;
    logic        vb_d;
    logic        frame_pulse;
    logic        step_tick;
    logic [7:0]  fcnt;
    logic [7:0]  period;
    logic [10:0] nx_right;
    logic [10:0] ny;
    logic        can_right;
    logic        can_left;
    logic        at_edge;
    logic        descend;

    always_comb begin
        vb          = (v_counter == 10'(V_ACTIVE)) && (h_counter == 10'd0);
        frame_pulse = vb && !vb_d;
        step_tick   = frame_pulse && (fcnt >= period - 8'd1);
        nx_right    = {1'b0, posX} + 11'(STEP_X);
        ny          = {1'b0, posY} + 11'(STEP_Y);
        can_right   = nx_right <= 11'(X_MAX);
        can_left    = {1'b0, posX} >= 11'(X_MIN + STEP_X);
        at_edge     = dir ? !can_left : !can_right;
        // a same-cycle hit wins over the step, so it must also block descent
        descend     = (state == MOVE) && !hit && step_tick && at_edge;
    end

`ifdef INIMIGO_ACCEL_EN
    logic [7:0] cur_period;

    assign period = cur_period;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_period <= 8'(FRAMES_PER_STEP);
        end else if (descend) begin
            if (cur_period > 8'(FRAMES_MIN))
                cur_period <= cur_period - 8'd1;
            else
                cur_period <= 8'(FRAMES_MIN);
        end
    end
`else
    localparam int unused_frames_min = FRAMES_MIN;

    assign period = 8'(FRAMES_PER_STEP);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vb_d <= 1'b0;
            fcnt <= 8'd0;
        end else begin
            vb_d <= vb;
            if (step_tick)
                fcnt <= 8'd0;
            else if (frame_pulse)
                fcnt <= fcnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= MOVE;
            posX   <= 10'(X_START);
            posY   <= 10'(Y_START);
            dir    <= 1'b0;
            alive  <= 1'b1;
            landed <= 1'b0;
        end else begin
            unique case (state)
                MOVE: begin
                    if (hit) begin
                        alive <= 1'b0;
                        state <= DEAD;
                    end else if (step_tick) begin
                        if (!at_edge) begin
                            if (dir)
                                posX <= posX - 10'(STEP_X);
                            else
                                posX <= nx_right[9:0];
                        end else begin
                            dir <= !dir;
                            if (ny >= 11'(Y_LIMIT)) begin
                                posY   <= 10'(Y_LIMIT);
                                landed <= 1'b1;
                                state  <= LANDED;
                            end else begin
                                posY <= ny[9:0];
                            end
                        end
                    end
                end
                DEAD: begin
                    state <= DEAD;
                end
                LANDED: begin
                    state <= LANDED;
                end
                default: begin
                    state <= MOVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inimigo_movimento.sv
// Directed bench for inimigo_movimento: reset, march, edge reversal, kill, landing.
// Three instances share the raster counters; accel check runs when INIMIGO_ACCEL_EN is set.
module tb_inimigo_movimento;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] h_counter = 10'd1;
    logic [9:0] v_counter = 10'd0;
    logic       hit_m = 1'b0;
    logic       hit_e = 1'b0;
    logic       hit_l = 1'b0;

    logic [9:0] px_m, py_m, px_e, py_e, px_l, py_l;
    logic       al_m, ld_m, dr_m, al_e, ld_e, dr_e, al_l, ld_l, dr_l;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inimigo_movimento dut_m (
        .clk(clk), .reset(reset), .h_counter(h_counter), .v_counter(v_counter),
        .hit(hit_m), .posX(px_m), .posY(py_m), .alive(al_m), .landed(ld_m), .dir(dr_m)
    );

    inimigo_movimento #(.X_START(606)) dut_e (
        .clk(clk), .reset(reset), .h_counter(h_counter), .v_counter(v_counter),
        .hit(hit_e), .posX(px_e), .posY(py_e), .alive(al_e), .landed(ld_e), .dir(dr_e)
    );

    inimigo_movimento #(.X_START(606), .Y_START(412)) dut_l (
        .clk(clk), .reset(reset), .h_counter(h_counter), .v_counter(v_counter),
        .hit(hit_l), .posX(px_l), .posY(py_l), .alive(al_l), .landed(ld_l), .dir(dr_l)
    );

`ifdef INIMIGO_ACCEL_EN
    logic       rst_a = 1'b1;
    logic       hit_a = 1'b0;
    logic [9:0] px_a, py_a;
    logic       al_a, ld_a, dr_a;

    inimigo_movimento #(
        .X_START(100), .X_MIN(100), .X_MAX(100),
        .FRAMES_PER_STEP(7), .FRAMES_MIN(5)
    ) dut_a (
        .clk(clk), .reset(rst_a), .h_counter(h_counter), .v_counter(v_counter),
        .hit(hit_a), .posX(px_a), .posY(py_a), .alive(al_a), .landed(ld_a), .dir(dr_a)
    );
`endif

    task automatic frame();
        @(posedge clk); #1;
        v_counter = 10'd480;
        h_counter = 10'd0;
        repeat (5) @(posedge clk);
        #1;
        v_counter = 10'd0;
        h_counter = 10'd1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        frames(10);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (px_m !== 10'd100) begin
            failures++;
            $display("FAIL reset_posX got=%0d exp=100", px_m);
        end
        checks++;
        if (py_m !== 10'd40) begin
            failures++;
            $display("FAIL reset_posY got=%0d exp=40", py_m);
        end
        checks++;
        if (al_m !== 1'b1) begin
            failures++;
            $display("FAIL reset_alive got=%b exp=1", al_m);
        end
        checks++;
        if (ld_m !== 1'b0) begin
            failures++;
            $display("FAIL reset_landed got=%b exp=0", ld_m);
        end
        checks++;
        if (dr_m !== 1'b0) begin
            failures++;
            $display("FAIL reset_dir got=%b exp=0", dr_m);
        end
        frames(29);
        checks++;
        if (px_m !== 10'd100) begin
            failures++;
            $display("FAIL reset_29frames_posX got=%0d exp=100", px_m);
        end
    endtask

    task automatic test_march();
        frame();
        checks++;
        if (px_m !== 10'd104) begin
            failures++;
            $display("FAIL march_step1 got=%0d exp=104", px_m);
        end
        checks++;
        if (py_m !== 10'd40) begin
            failures++;
            $display("FAIL march_posY got=%0d exp=40", py_m);
        end
    endtask

    task automatic test_edge();
        checks++;
        if (px_e !== 10'd606) begin
            failures++;
            $display("FAIL edge_posX got=%0d exp=606", px_e);
        end
        checks++;
        if (py_e !== 10'd52) begin
            failures++;
            $display("FAIL edge_posY got=%0d exp=52", py_e);
        end
        checks++;
        if (dr_e !== 1'b1) begin
            failures++;
            $display("FAIL edge_dir got=%b exp=1", dr_e);
        end
    endtask

    task automatic test_landing();
        checks++;
        if (py_l !== 10'd420) begin
            failures++;
            $display("FAIL land_posY got=%0d exp=420", py_l);
        end
        checks++;
        if (ld_l !== 1'b1) begin
            failures++;
            $display("FAIL land_flag got=%b exp=1", ld_l);
        end
        @(posedge clk); #1;
        hit_l = 1'b1;
        @(posedge clk); #1;
        hit_l = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (al_l !== 1'b1) begin
            failures++;
            $display("FAIL land_hit_alive got=%b exp=1", al_l);
        end
    endtask

    task automatic test_second_period();
        frames(30);
        checks++;
        if (px_e !== 10'd602) begin
            failures++;
            $display("FAIL edge_next_posX got=%0d exp=602", px_e);
        end
        checks++;
        if (px_m !== 10'd108) begin
            failures++;
            $display("FAIL march_step2 got=%0d exp=108", px_m);
        end
        checks++;
        if (px_l !== 10'd606 || py_l !== 10'd420) begin
            failures++;
            $display("FAIL land_frozen got=%0d,%0d exp=606,420", px_l, py_l);
        end
    endtask

    task automatic test_kill();
        frames(29);
        @(posedge clk); #1;
        v_counter = 10'd480;
        h_counter = 10'd0;
        hit_m = 1'b1;
        @(posedge clk); #1;
        hit_m = 1'b0;
        checks++;
        if (al_m !== 1'b0) begin
            failures++;
            $display("FAIL kill_alive got=%b exp=0", al_m);
        end
        checks++;
        if (px_m !== 10'd108) begin
            failures++;
            $display("FAIL kill_tick_discarded got=%0d exp=108", px_m);
        end
        repeat (4) @(posedge clk);
        #1;
        v_counter = 10'd0;
        h_counter = 10'd1;
        repeat (2) @(posedge clk);
        frames(100);
        checks++;
        if (px_m !== 10'd108 || py_m !== 10'd40) begin
            failures++;
            $display("FAIL kill_frozen got=%0d,%0d exp=108,40", px_m, py_m);
        end
        checks++;
        if (py_l !== 10'd420 || px_l !== 10'd606) begin
            failures++;
            $display("FAIL land_frozen_late got=%0d,%0d exp=606,420", px_l, py_l);
        end
    endtask

`ifdef INIMIGO_ACCEL_EN
    task automatic test_accel();
        int exp_gap [4] = '{7, 6, 5, 5};
        int cnt;
        logic [9:0] prev;
        @(posedge clk); #1;
        rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            prev = py_a;
            while (cnt < 20 && py_a === prev) begin
                frame();
                cnt++;
            end
            checks++;
            if (cnt != exp_gap[k]) begin
                failures++;
                $display("FAIL accel_gap%0d got=%0d exp=%0d", k, cnt, exp_gap[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_march();
        test_edge();
        test_landing();
        test_second_period();
        test_kill();
`ifdef INIMIGO_ACCEL_EN
        test_accel();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
